// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined two-level carry-lookahead adder/subtractor built from 4-bit
//   lookahead groups. Stage 1 registers the effective operands together with
//   the bit and group propagate/generate terms. Stage 2 registers the result,
//   which comes from a flat lookahead across groups and then within each group.
//   The block accepts one operation per cycle when the output is not stalled.
//
// Ports
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid / in_ready  input handshake (a, b, cin, sub)
//   a, b                 operands, WIDTH bits
//   cin                  carry-in, ignored when sub=1
//   sub                  1: a - b, 0: a + b + cin
//   out_valid/out_ready  output handshake (sum, cout, ovf, zero, p_out, g_out)
//   sum                  result modulo 2^WIDTH
//   cout                 carry out of the MSB (for subtract, 1 = no borrow)
//   ovf                  signed two's-complement overflow
//   zero                 sum == 0
//   p_out, g_out         word propagate / generate, used to chain instances
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data steady until that edge. ready
// may depend combinationally on the downstream ready (in_ready follows
// out_ready), but valid never depends on ready.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             p_out,
    output logic             g_out
);

    localparam int NGRP = WIDTH / 4;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !s1_valid || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Level 1: effective operands, bit and group propagate/generate
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic             c0;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_g;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
        bit_p = a ^ b_eff;
        bit_g = a & b_eff;
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NGRP; k++) begin
            grp_p[k] = &bit_p[4*k +: 4];
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers (load on accept)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b_eff;
    logic             s1_c0;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NGRP-1:0]  s1_gp;
    logic [NGRP-1:0]  s1_gg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b_eff <= '0;
            s1_c0    <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= a;
                s1_b_eff <= b_eff;
                s1_c0    <= c0;
                s1_p     <= bit_p;
                s1_g     <= bit_g;
                s1_gp    <= grp_p;
                s1_gg    <= grp_g;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Level 2: flat lookahead across groups, then within each group.
    // Every carry is an OR of product terms taken directly from the stage-1
    // registers; no carry is derived from a neighbouring carry of the same
    // level, so there is no ripple path.
    // ------------------------------------------------------------------
    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] bit_c;
    logic             word_g;
    logic [WIDTH-1:0] nxt_sum;
    logic             nxt_cout;
    logic             nxt_ovf;
    logic             nxt_zero;
    logic             nxt_p;

    always_comb begin : lookahead
        logic acc;
        logic term;
        grp_c    = '0;
        bit_c    = '0;
        word_g   = 1'b0;
        acc      = 1'b0;
        term     = 1'b0;
        grp_c[0] = s1_c0;

        // C[k+1] = G[k] | P[k]G[k-1] | ... | P[k]..P[0]c0
        for (int k = 0; k < NGRP; k++) begin
            acc = s1_c0;
            for (int m = 0; m <= k; m++) acc = acc & s1_gp[m];
            for (int j = 0; j <= k; j++) begin
                term = s1_gg[j];
                for (int m = j + 1; m <= k; m++) term = term & s1_gp[m];
                acc = acc | term;
            end
            grp_c[k+1] = acc;
        end

        // Word generate: same sum-of-products with the carry-in term dropped.
        word_g = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            term = s1_gg[j];
            for (int m = j + 1; m < NGRP; m++) term = term & s1_gp[m];
            word_g = word_g | term;
        end

        // In-group carries, flat lookahead from the group carry-in.
        for (int k = 0; k < NGRP; k++) begin
            for (int i = 0; i < 4; i++) begin
                acc = grp_c[k];
                for (int m = 0; m < i; m++) acc = acc & s1_p[4*k+m];
                for (int j = 0; j < i; j++) begin
                    term = s1_g[4*k+j];
                    for (int m = j + 1; m < i; m++) term = term & s1_p[4*k+m];
                    acc = acc | term;
                end
                bit_c[4*k+i] = acc;
            end
        end

        // Bit propagate is rebuilt from the stored effective operands here;
        // it equals s1_p bit for bit.
        nxt_sum  = s1_a ^ s1_b_eff ^ bit_c;
        nxt_cout = grp_c[NGRP];
        nxt_ovf  = bit_c[WIDTH-1] ^ grp_c[NGRP];
        nxt_zero = (nxt_sum == '0);
        nxt_p    = &s1_gp;
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (load on stage-1 advance, hold during stall)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            p_out    <= 1'b0;
            g_out    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_adv) begin
                sum   <= nxt_sum;
                cout  <= nxt_cout;
                ovf   <= nxt_ovf;
                zero  <= nxt_zero;
                p_out <= nxt_p;
                g_out <= word_g;
            end
        end
    end

endmodule
